// File: rtl/bp_nonsynth_stall_hist_counters.sv
// bp_nonsynth_stall_hist_counters: saturating stall-class histogram with a 1-deep valid/yumi read port; BP_STALL_HIST_SNAPSHOT_EN adds a shadow bank
module bp_nonsynth_stall_hist_counters #(
  parameter int num_reasons_p = 64,
  parameter int cnt_width_p = 32,
  localparam int lg_reasons_lp = (num_reasons_p > 1) ? $clog2(num_reasons_p) : 1,
  localparam int addr_width_lp = $clog2(num_reasons_p + 3)
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     freeze_i,
  input  logic                     instret_i,
  input  logic                     stall_v_i,
  input  logic [lg_reasons_lp-1:0] stall_reason_i,
  input  logic                     clear_i,
  input  logic                     snap_i,
  input  logic                     rd_v_i,
  input  logic [addr_width_lp-1:0] rd_addr_i,
  output logic                     rd_ready_o,
  output logic                     rd_v_o,
  output logic [cnt_width_p-1:0]   rd_data_o,
  input  logic                     rd_yumi_i
);
  localparam int ctrs_lp = num_reasons_p + 3;
  typedef enum logic {e_idle, e_resp} state_e;
  state_e state_r, state_n;
  logic en, stall_hit;
  logic [ctrs_lp-1:0] inc;
  logic [cnt_width_p-1:0] ctr_r [ctrs_lp];
  logic [cnt_width_p-1:0] src [ctrs_lp];
  logic [cnt_width_p-1:0] rd_val, rd_data_r;
  assign en = ~reset_i & ~freeze_i;
  // exactly one class counter (reason, instret or unclassified) bumps per enabled cycle
  always_comb begin
    inc = '0;
    stall_hit = 1'b0;
    for (int i = 0; i < num_reasons_p; i++)
      if (stall_v_i && !instret_i && stall_reason_i == lg_reasons_lp'(i)) begin
        inc[i] = en;
        stall_hit = 1'b1;
      end
    inc[num_reasons_p] = en;
    inc[num_reasons_p+1] = en & instret_i;
    inc[num_reasons_p+2] = en & ~instret_i & ~stall_hit;
  end
  always_ff @(posedge clk_i)
    for (int i = 0; i < ctrs_lp; i++)
      if (reset_i | clear_i) ctr_r[i] <= '0;
      else if (inc[i] && !(&ctr_r[i])) ctr_r[i] <= ctr_r[i] + cnt_width_p'(1);
`ifdef BP_STALL_HIST_SNAPSHOT_EN
  logic [cnt_width_p-1:0] shadow_r [ctrs_lp];
  always_ff @(posedge clk_i)
    for (int i = 0; i < ctrs_lp; i++)
      if (reset_i) shadow_r[i] <= '0;
      else if (snap_i) shadow_r[i] <= clear_i ? '0 : ctr_r[i];
  assign src = shadow_r;
`else
  assign src = ctr_r;
`endif
  always_comb begin
    rd_val = '0;
    for (int i = 0; i < ctrs_lp; i++)
      if (rd_addr_i == addr_width_lp'(i)) rd_val = src[i];
  end
  always_ff @(posedge clk_i)
    state_r <= reset_i ? e_idle : state_n;
  always_comb
    state_n = (state_r == e_idle) ? (rd_v_i ? e_resp : e_idle) : (rd_yumi_i ? e_idle : e_resp);
  always_comb begin
    rd_ready_o = ~reset_i & (state_r == e_idle);
    rd_v_o = ~reset_i & (state_r == e_resp);
  end
  always_ff @(posedge clk_i)
    if (reset_i) rd_data_r <= '0;
    else if (state_r == e_idle && rd_v_i) rd_data_r <= rd_val;
  assign rd_data_o = rd_data_r;
endmodule
